// File: rtl/lcd_bus_timing_8bit_if.sv
// Sequencer-to-LCD timing bundle: byte request and status on one side, LCD pins on the other.
interface lcd_bus_timing_8bit_if;
  logic [7:0] data;
  logic       cd;
  logic       start;
  logic       rs;
  logic       en;
  logic [7:0] lcd_data;
  logic       done_tick;
  logic       busy;

  modport master (
    output data, cd, start,
    input  rs, en, lcd_data, done_tick, busy
  );

  modport slave (
    input  data, cd, start,
    output rs, en, lcd_data, done_tick, busy
  );
endinterface

// File: rtl/lcd_bus_timing_8bit.sv
// HD44780 8-bit write-only bus timing engine: power-on wait, setup/pulse/hold, execution wait.
// Optional macro LCD_LONG_EXEC_EN gives clear/home commands the long execution wait.
module lcd_bus_timing_8bit #(
  parameter int unsigned POWERON_CYC   = 750000,
  parameter int unsigned SETUP_CYC     = 3,
  parameter int unsigned PULSE_CYC     = 15,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2500,
  parameter int unsigned LONG_EXEC_CYC = 82000,
  parameter int unsigned CNT_W         = 20
) (
  input logic                 clk,
  input logic                 rst,
  lcd_bus_timing_8bit_if.slave bus_io
);

  localparam logic [2:0] StPwrup = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StSetup = 3'd2;
  localparam logic [2:0] StPulse = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;
  localparam logic [2:0] StExec  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  localparam logic [CNT_W-1:0] PwrLast   = CNT_W'(POWERON_CYC - 1);
  localparam logic [CNT_W-1:0] SetupLast = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ExecLast  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LongLast  = CNT_W'(LONG_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             long_q, long_d;
  logic             long_sel;

`ifdef LCD_LONG_EXEC_EN
  assign long_sel = ~bus_io.cd & ((bus_io.data == 8'h01) | (bus_io.data == 8'h02));
`else
  assign long_sel = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    done_d  = 1'b0;
    case (state_q)
      // Power-on counts up from the reset value of zero.
      StPwrup: begin
        if (cnt_q == PwrLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StIdle: begin
        if (bus_io.start) begin
          state_d = StSetup;
          cnt_d   = SetupLast;
          rs_d    = bus_io.cd;
          data_d  = bus_io.data;
          long_d  = long_sel;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = PulseLast;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLast;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StExec;
          cnt_d   = long_q ? LongLast : ExecLast;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StPwrup;
        cnt_d   = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StPwrup;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
      long_q  <= long_d;
    end
  end

  assign bus_io.rs        = rs_q;
  assign bus_io.en        = en_q;
  assign bus_io.lcd_data  = data_q;
  assign bus_io.done_tick = done_q;
  assign bus_io.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_bus_timing_8bit.sv
// Scoreboard bench: stimulus predicts each transfer's accept edge and latency from the
// timing rules; a negedge monitor checks pins every cycle and pops on done_tick.
module tb_lcd_bus_timing_8bit;

  localparam int PWR   = 20;
  localparam int SET   = 2;
  localparam int PUL   = 4;
  localparam int HLD   = 1;
  localparam int EXE   = 10;
  localparam int LEXE  = 50;

  typedef struct {
    logic [7:0] data;
    logic       cd;
    int         a;
    int         lat;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  lcd_bus_timing_8bit_if bus ();

  lcd_bus_timing_8bit #(
    .POWERON_CYC  (PWR),
    .SETUP_CYC    (SET),
    .PULSE_CYC    (PUL),
    .HOLD_CYC     (HLD),
    .EXEC_CYC     (EXE),
    .LONG_EXEC_CYC(LEXE),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  txn_t       q[$];
  int         ready = 0;
  logic [7:0] last_d = 8'h00;
  logic       last_rs = 1'b0;
  logic       acc;
  int         last_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, got, exp);
  endtask

  // Datasheet latency: setup + pulse + hold + exec, edges from accept to done_tick.
  function automatic int lat_of(input logic [7:0] d, input logic c);
    int e;
    e = EXE;
`ifdef LCD_LONG_EXEC_EN
    if (!c && (d == 8'h01 || d == 8'h02)) e = LEXE;
`endif
    return SET + PUL + HLD + e;
  endfunction

  // Drive inputs for the next edge and advance the reference model for that edge.
  task automatic step(input logic r, input logic s, input logic [7:0] d, input logic c);
    int   m;
    txn_t t;
    m         = cyc + 1;
    rst       = r;
    bus.start = s;
    bus.data  = d;
    bus.cd    = c;
    acc       = 1'b0;
    if (r) begin
      q.delete();
      ready   = m + PWR + 1;
      last_d  = 8'h00;
      last_rs = 1'b0;
    end else if (s && m >= ready) begin
      t.data = d;
      t.cd   = c;
      t.a    = m;
      t.lat  = lat_of(d, c);
      q.push_back(t);
      ready  = m + t.lat + 2;
      acc    = 1'b1;
      last_a = m;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] d, input logic c);
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, d, c);
      if (acc) break;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 8'($urandom), 1'($urandom));
  endtask

  // Monitor: per-cycle pin checks, pop and compare on done_tick.
  int         n;
  logic       exp_en, exp_busy, exp_rs;
  logic [7:0] exp_d;
  txn_t       tm;

  always @(negedge clk) begin
    n = cyc;
    if (q.size() > 0) begin
      exp_en   = (n >= q[0].a + SET) && (n < q[0].a + SET + PUL);
      exp_d    = q[0].data;
      exp_rs   = q[0].cd;
      exp_busy = 1'b1;
    end else begin
      exp_en   = 1'b0;
      exp_d    = last_d;
      exp_rs   = last_rs;
      exp_busy = (n < ready - 1);
    end
    chk("en", 32'(bus.en), 32'(exp_en));
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("rs", 32'(bus.rs), 32'(exp_rs));
    chk("lcd_data", 32'(bus.lcd_data), 32'(exp_d));
    if (bus.done_tick === 1'b1) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL done_unexpected at edge %0d: got done_tick 1 expected 0", n);
      end else begin
        tm = q.pop_front();
        chk("done_time", 32'(n), 32'(tm.a + tm.lat));
        last_d  = tm.data;
        last_rs = tm.cd;
      end
    end else if (q.size() > 0 && n > q[0].a + q[0].lat) begin
      n_total++;
      $display("FAIL done_timeout at edge %0d: got no done_tick expected at edge %0d",
               n, q[0].a + q[0].lat);
      tm = q.pop_front();
      last_d  = tm.data;
      last_rs = tm.cd;
    end
  end

  initial begin
    logic [7:0] d;
    int         r;
    step(1'b1, 1'b1, 8'h38, 1'b0);
    step(1'b1, 1'b1, 8'h38, 1'b0);
    xfer(8'h38, 1'b0);
    idle(22);
    xfer(8'h48, 1'b1);
    idle(22);
    xfer(8'h01, 1'b0);
    idle(3);
    xfer(8'h02, 1'b0);
    idle(3);
    xfer(8'h01, 1'b1);
    idle(3);
    // Inputs wiggle while the transfer is in flight; none of it may be taken.
    xfer(8'h41, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'(i % 2), 8'hFF, 1'b0);
    idle(5);
    // Reset lands while en is high.
    xfer(8'h43, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    xfer(8'h50, 1'b0);
    idle(20);
    // start held across three transfers.
    xfer(8'h48, 1'b1);
    xfer(8'h45, 1'b1);
    xfer(8'h4C, 1'b1);
    idle(22);
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 7));
      d = (r == 0) ? 8'h01 : (r == 1) ? 8'h02 : 8'($urandom);
      step(1'b0, 1'($urandom_range(0, 3) != 0), d, 1'($urandom));
    end
    idle(80);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
